// File: rtl/pong_pkg.sv
// Shared Pong encodings: match state (also drives LD3/LD5/LD6/LD7 and the
// ball state machine), winner code and score width.
package pong_pkg;
  localparam int SCORE_W = 4;

  typedef enum logic [1:0] {
    QI      = 2'b00,
    QGAME_1 = 2'b01,
    QGAME_2 = 2'b10,
    QDONE   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;
endpackage

// File: rtl/pong_match_ctrl_if.sv
// Match-control bus: game events and switch in, state/score/ball control out.
interface pong_match_ctrl_if;
  import pong_pkg::*;

  logic                tick;
  logic                start;
  logic                p1_miss;
  logic                p2_miss;
  state_t              state;
  logic                ball_run;
  logic                serve_dir;
  logic [SCORE_W-1:0]  p1_score;
  logic [SCORE_W-1:0]  p2_score;
  winner_t             winner;

  modport master (
    output tick, start, p1_miss, p2_miss,
    input  state, ball_run, serve_dir, p1_score, p2_score, winner
  );

  modport slave (
    input  tick, start, p1_miss, p2_miss,
    output state, ball_run, serve_dir, p1_score, p2_score, winner
  );
endinterface

// File: rtl/pong_serve_timer.sv
// Serve hold-off counter: load reloads SERVE_DELAY, each tick counts down to 0.
module pong_serve_timer #(
  parameter int SERVE_DELAY = 64,
  localparam int W = $clog2(SERVE_DELAY + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic zero_next
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = W'(SERVE_DELAY);
    else if (tick && cnt_q != '0)
      cnt_d = cnt_q - W'(1);
    // Zero as of the coming edge, so the caller can register ball_run on the
    // same edge that consumes the final tick.
    zero_next = (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match flow: idle / serve / rally / game-over sequencing and scoring.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 10,
  parameter int SERVE_DELAY = 64
) (
  input  logic              clk,
  input  logic              reset,
  pong_match_ctrl_if.slave  bus
);
  localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);

  state_t             state_q, state_d;
  winner_t            win_q, win_d;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d, p1_inc, p2_inc;
  logic               ball_run_q, ball_run_d;
  logic               serve_dir_q, serve_dir_d;
  logic               start_q, start_edge;
  logic               load, zero_next;

  pong_serve_timer #(.SERVE_DELAY(SERVE_DELAY)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .tick      (bus.tick),
    .zero_next (zero_next)
  );

  assign start_edge = bus.start & ~start_q;
  assign p1_inc     = p1_q + SCORE_W'(1);
  assign p2_inc     = p2_q + SCORE_W'(1);

  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    win_d   = win_q;
    load    = 1'b0;
    case (state_q)
      QI: begin
        p1_d  = '0;
        p2_d  = '0;
        win_d = WIN_NONE;
        if (start_edge) begin
          state_d = QGAME_1;
          load    = 1'b1;
        end
      end
      QGAME_1, QGAME_2: begin
        if (!bus.start) begin
          state_d = QI;
          p1_d    = '0;
          p2_d    = '0;
          win_d   = WIN_NONE;
        end else if (ball_run_q && bus.p1_miss && bus.p2_miss) begin
          load = 1'b1;
        end else if (ball_run_q && bus.p2_miss) begin
          p1_d = p1_inc;
          load = 1'b1;
          if (p1_inc == WIN_S) begin
            state_d = QDONE;
            win_d   = WIN_P1;
          end else begin
            state_d = QGAME_2;
          end
        end else if (ball_run_q && bus.p1_miss) begin
          p2_d = p2_inc;
          load = 1'b1;
          if (p2_inc == WIN_S) begin
            state_d = QDONE;
            win_d   = WIN_P2;
          end else begin
            state_d = QGAME_1;
          end
        end
      end
      QDONE: begin
        if (!bus.start) begin
          state_d = QI;
          p1_d    = '0;
          p2_d    = '0;
          win_d   = WIN_NONE;
        end
      end
      default: state_d = QI;
    endcase
    // A point reloads the timer, so zero_next is low and the ball is held.
    ball_run_d  = (state_d == QGAME_1 || state_d == QGAME_2) && zero_next;
    serve_dir_d = (state_d == QGAME_2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= QI;
      p1_q        <= '0;
      p2_q        <= '0;
      win_q       <= WIN_NONE;
      ball_run_q  <= 1'b0;
      serve_dir_q <= 1'b0;
      start_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      win_q       <= win_d;
      ball_run_q  <= ball_run_d;
      serve_dir_q <= serve_dir_d;
      start_q     <= bus.start;
    end
  end

  assign bus.state     = state_q;
  assign bus.p1_score  = p1_q;
  assign bus.p2_score  = p2_q;
  assign bus.winner    = win_q;
  assign bus.ball_run  = ball_run_q;
  assign bus.serve_dir = serve_dir_q;
endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match-flow controller for the Pong game. It consumes the single-cycle miss events from the ball state machine and the start switch, and keeps the score. It sequences idle / serve / rally / game-over and produces the `state`, score and winner signals that drive the LEDs and seven-segment display. It also produces the ball-enable and serve-direction signals that feed back into the ball state machine.

## Interface
- `WIN_SCORE`, 10: score that ends the match; must be ≤ 15.
- `SERVE_DELAY`, 64: number of `tick` pulses the ball is held before each serve; must be ≥ 1.
- `clk` in 1: game clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `tick` in 1: single-cycle game-update strobe, one per paddle/ball update.
- `start` in 1: start switch, level, already synchronous to `clk`.
- `p1_miss` in 1: single-cycle pulse; ball passed player 1's edge, so player 2 scores.
- `p2_miss` in 1: single-cycle pulse; ball passed player 2's edge, so player 1 scores.
- `state` out 2: `QI`=00, `QGAME_1`=01 (player 1 serving), `QGAME_2`=10 (player 2 serving), `QDONE`=11.
- `ball_run` out 1: 1 means the ball moves; 0 means the ball is held at centre.
- `serve_dir` out 1: 0 means serve toward player 2, 1 means serve toward player 1.
- `p1_score`, `p2_score` out 4: current scores, binary.
- `winner` out 2: 00 none, 01 player 1, 10 player 2.

## Operation
- All outputs are registered.
- Reset values:
  - `state`=`QI`, `ball_run`=0, `serve_dir`=0, both scores 0, `winner`=00.
  - The internal `start_q` resets to 1, so a switch already high at reset does not start a game.
- Start edge is `start & ~start_q`; `start_q` samples `start` every cycle.
- `QI`:
  - Scores and winner are held at 0; `ball_run`=0.
  - On a start edge, go to `QGAME_1`, load the serve counter with `SERVE_DELAY`, and set `serve_dir`=0.
- `QGAME_1` / `QGAME_2`:
  - While the serve counter ≠ 0, each `tick` decrements it and `ball_run` stays 0.
  - When the counter is 0, `ball_run`=1.
  - `serve_dir` is 0 in `QGAME_1` and 1 in `QGAME_2`.
- Point scoring, only when `ball_run`=1:
  - `p2_miss` alone increments `p1_score`; the next state is `QGAME_2` (the conceding player serves).
  - `p1_miss` alone increments `p2_score`; the next state is `QGAME_1`.
  - After a point: reload the counter with `SERVE_DELAY` and set `ball_run`=0.
- Misses while `ball_run`=0, or in `QI` / `QDONE`, are ignored.
- Simultaneous `p1_miss` and `p2_miss`:
  - No score change.
  - Re-serve by the current server: state is unchanged, counter reloads, `ball_run` drops.
- Win:
  - If the incremented score equals `WIN_SCORE`, go to `QDONE` and set `winner` to the scorer.
  - `ball_run`=0; scores are frozen.
  - Scores never exceed `WIN_SCORE`.
- `QDONE`:
  - Holds scores and winner while `start`=1.
  - `start`=0 returns to `QI` next cycle, clearing scores and `winner`.
- `start`=0 in `QGAME_x` aborts to `QI` next cycle, with scores cleared.
- Priority within a cycle, highest first: `reset`, abort (`start`=0), miss, `tick`.
  - A miss and a `tick` in the same cycle: the miss wins and the counter reloads without decrementing.

## Timing
- A miss pulse sampled at edge N shows the updated score, `state`, `winner` and `ball_run`=0 after edge N.
- Start edge:
  - `start` rises before edge N; `state`=`QGAME_1` after edge N.
  - `ball_run` rises after the edge that samples the `SERVE_DELAY`-th `tick`.
- Abort and `QDONE`→`QI` each take exactly 1 cycle.
- Asserting `reset` mid-rally clears every output asynchronously, with no clock required.
- No combinational path from any input to any output.

## Structure
- Shared package `pong_pkg`:
  - State encodings `QI` / `QGAME_1` / `QGAME_2` / `QDONE`.
  - Winner encodings.
  - Score width constant (4).
- The same state encoding drives LD3/LD5/LD6/LD7 and the ball state machine.
- One sub-module, `pong_serve_timer`:
  - Inputs: load, tick.
  - Outputs: count = 0.
  - Width is `$clog2(SERVE_DELAY+1)`.
- Everything else is one FSM plus score registers in `pong_match_ctrl`.

## Test plan
- Reset with `start`=1 held, then run 10 ticks → `state` stays `QI`, and every output is at its reset value.
- `start` 0→1 with `SERVE_DELAY`=4 →
  - `state`=01 one cycle later.
  - `ball_run`=0 through 3 ticks; `ball_run`=1 after the 4th tick.
  - `serve_dir`=0.
- During a rally, `p2_miss` pulse → `p1_score`=1 and `state`=10 next cycle, with `serve_dir`=1 and `ball_run`=0. A `p1_miss` while held → no change.
- Both misses in one cycle with `ball_run`=1 → scores unchanged, counter reloaded, `ball_run`=0.
- Win and return to idle:
  - Drive `p1_score` to 9, then a `p2_miss` → `p1_score`=10, `state`=11, `winner`=01.
  - Further misses → no change.
  - `start`=0 → `state`=00 and scores 0 next cycle.
- Abort and reset:
  - `start`=0 mid-rally at score 3–2 → `QI` with scores 0.
  - Separately, `reset` pulsed between clock edges → all outputs cleared before the next edge.
